muldiv_sequencer: RTL and testbench

//  Multi-cycle sequencer for RV32M MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU in the EX stage.

---
 rtl/muldiv_sequencer_if.sv | 31 +++
 rtl/muldiv_sequencer.sv | 245 ++++++++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_if.sv
// Purpose: request/response bundle between the EX stage and the M-extension sequencer.
// Latency: none (wires only).
// Backpressure: req_ready_o/stall_o from the slave hold the requester; resp_valid_o is a one-cycle pulse.
interface muldiv_sequencer_if #(
  parameter int XLEN = 32
);
  logic            req_valid_i;
  logic [2:0]      op_i;
  logic [XLEN-1:0] rs1_i;
  logic [XLEN-1:0] rs2_i;
  logic [4:0]      rd_addr_i;
  logic            flush_i;
  logic            req_ready_o;
  logic            busy_o;
  logic            stall_o;
  logic            resp_valid_o;
  logic [XLEN-1:0] result_o;
  logic [4:0]      rd_addr_o;

  // Sequencer side
  modport slave (
    input  req_valid_i, op_i, rs1_i, rs2_i, rd_addr_i, flush_i,
    output req_ready_o, busy_o, stall_o, resp_valid_o, result_o, rd_addr_o
  );

  // Pipeline / requester side
  modport master (
    output req_valid_i, op_i, rs1_i, rs2_i, rd_addr_i, flush_i,
    input  req_ready_o, busy_o, stall_o, resp_valid_o, result_o, rd_addr_o
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Purpose: iterative RV32M MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU sequencer (shift-add / restoring divide).
// Latency: accept -> resp_valid_o after XLEN/UNROLL+3 cycles; 2 cycles for trivial ops when MULDIV_EARLY_OUT_EN is defined.
// Backpressure: accepts only in IDLE; stall_o holds the pipeline from the accept cycle until FIXUP; flush_i aborts.
module muldiv_sequencer #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1   // bits per CALC cycle: 1, 2 or 4, must divide XLEN
) (
  input  logic              clk,
  input  logic              rst_n,
  muldiv_sequencer_if.slave bus
);

  localparam int STEPS = XLEN / UNROLL;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STEPS - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_PREP  = 3'd1;
  localparam logic [2:0] ST_CALC  = 3'd2;
  localparam logic [2:0] ST_FIXUP = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0]      state_q,  state_d;
  logic [2:0]      op_q,     op_d;
  logic [4:0]      rd_q,     rd_d;      // rd captured at accept
  logic [4:0]      rd_out_q, rd_out_d;  // rd presented with the result
  logic [XLEN-1:0] hi_q,     hi_d;      // product high half / partial remainder
  logic [XLEN-1:0] lo_q,     lo_d;      // multiplier -> product low half / dividend -> quotient
  logic [XLEN-1:0] opb_q,    opb_d;     // multiplicand / divisor magnitude
  logic [XLEN-1:0] result_q, result_d;
  logic            neg_q,    neg_d;     // final result must be negated
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  // Operand decode. Between accept and PREP, lo_q holds raw rs1 and opb_q raw rs2,
  // so these terms are only meaningful while in PREP.
  logic            is_mul;
  logic            a_sgn;
  logic            b_sgn;
  logic            neg_a;
  logic            neg_b;
  logic            b_zero;
  logic            res_neg;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;

  // Classify signedness and magnitudes of the raw operands, and the result sign
  always_comb begin
    is_mul = ~op_q[2];
    a_sgn  = (op_q == 3'b001) | (op_q == 3'b010) | (op_q == 3'b100) | (op_q == 3'b110);
    b_sgn  = (op_q == 3'b001) | (op_q == 3'b100) | (op_q == 3'b110);
    neg_a  = a_sgn & lo_q[XLEN-1];
    neg_b  = b_sgn & opb_q[XLEN-1];
    b_zero = (opb_q == '0);
    abs_a  = neg_a ? -lo_q  : lo_q;
    abs_b  = neg_b ? -opb_q : opb_q;
    res_neg = 1'b0;
    case (op_q)
      3'b001, 3'b010: res_neg = neg_a ^ neg_b;
      // a zero divisor yields an all-ones quotient regardless of operand signs
      3'b100:         res_neg = (neg_a ^ neg_b) & ~b_zero;
      // remainder takes the sign of the dividend
      3'b110:         res_neg = neg_a;
      default:        res_neg = 1'b0;
    endcase
  end

  logic [XLEN-1:0] it_hi;
  logic [XLEN-1:0] it_lo;
  logic [XLEN:0]   sum;
  logic [XLEN:0]   diff;

  // UNROLL unsigned shift-add (multiply) or restoring shift-subtract (divide) steps
  always_comb begin
    it_hi = hi_q;
    it_lo = lo_q;
    sum   = '0;
    diff  = '0;
    for (int i = 0; i < UNROLL; i++) begin
      if (is_mul) begin
        sum   = {1'b0, it_hi} + (it_lo[0] ? {1'b0, opb_q} : '0);
        it_lo = {sum[0], it_lo[XLEN-1:1]};
        it_hi = sum[XLEN:1];
      end else begin
        // shifted remainder never exceeds 2*divisor-1, so XLEN+1 bits cannot overflow
        diff = {it_hi, it_lo[XLEN-1]} - {1'b0, opb_q};
        if (!diff[XLEN]) begin
          it_hi = diff[XLEN-1:0];
          it_lo = {it_lo[XLEN-2:0], 1'b1};
        end else begin
          it_hi = {it_hi[XLEN-2:0], it_lo[XLEN-1]};
          it_lo = {it_lo[XLEN-2:0], 1'b0};
        end
      end
    end
  end

  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   div_sel;
  logic [XLEN-1:0]   fix_res;

  // Apply the sign and pick product half or quotient/remainder
  always_comb begin
    prod     = {hi_q, lo_q};
    prod_fix = neg_q ? -prod : prod;
    div_sel  = op_q[1] ? hi_q : lo_q;
    if (is_mul) begin
      fix_res = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    end else begin
      fix_res = neg_q ? -div_sel : div_sel;
    end
  end

  logic            early_hit;
  logic [XLEN-1:0] early_res;

`ifdef MULDIV_EARLY_OUT_EN
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
  logic a_zero;
  logic ovf;

  // Detect ops whose architectural result is known from the raw operands
  always_comb begin
    a_zero    = (lo_q == '0);
    ovf       = op_q[2] & b_sgn & (lo_q == INT_MIN) & (opb_q == '1);
    early_hit = 1'b0;
    early_res = '0;
    if (is_mul) begin
      early_hit = a_zero | b_zero;
    end else begin
      early_hit = b_zero | ovf | a_zero;
      if (op_q[1]) begin
        early_res = b_zero ? lo_q : '0;
      end else begin
        early_res = b_zero ? '1 : (ovf ? INT_MIN : '0);
      end
    end
  end
`else
  assign early_hit = 1'b0;
  assign early_res = '0;
`endif

  // FSM sequencing and datapath register updates
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rd_d     = rd_q;
    rd_out_d = rd_out_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opb_d    = opb_q;
    result_d = result_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    if (bus.flush_i) begin
      // a flush kills any in-flight op and blocks a same-cycle accept
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.req_valid_i) begin
            state_d = ST_PREP;
            op_d    = bus.op_i;
            rd_d    = bus.rd_addr_i;
            lo_d    = bus.rs1_i;
            opb_d   = bus.rs2_i;
          end
        end
        ST_PREP: begin
          neg_d = res_neg;
          hi_d  = '0;
          lo_d  = is_mul ? abs_b : abs_a;
          opb_d = is_mul ? abs_a : abs_b;
          cnt_d = CNT_LOAD;
          if (early_hit) begin
            result_d = early_res;
            rd_out_d = rd_q;
            state_d  = ST_DONE;
          end else begin
            state_d  = ST_CALC;
          end
        end
        ST_CALC: begin
          hi_d  = it_hi;
          lo_d  = it_lo;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == '0) begin
            state_d = ST_FIXUP;
          end
        end
        ST_FIXUP: begin
          result_d = fix_res;
          rd_out_d = rd_q;
          state_d  = ST_DONE;
        end
        ST_DONE: begin
          // never accept here: the pipeline must first advance past this op
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      rd_q     <= '0;
      rd_out_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      result_q <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      rd_out_q <= rd_out_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
    end
  end

  // stall covers the accept cycle combinationally and drops in DONE so EX/MEM captures the result
  assign bus.req_ready_o  = (state_q == ST_IDLE);
  assign bus.busy_o       = (state_q != ST_IDLE);
  assign bus.stall_o      = ~bus.flush_i &
                            (((state_q == ST_IDLE) & bus.req_valid_i) |
                             (state_q == ST_PREP) | (state_q == ST_CALC) | (state_q == ST_FIXUP));
  assign bus.resp_valid_o = (state_q == ST_DONE) & ~bus.flush_i;
  assign bus.result_o     = result_q;
  assign bus.rd_addr_o    = rd_out_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Purpose: self-checking bench for muldiv_sequencer with a response scoreboard.
// Latency: checks accept-to-response latency and stall_o per op.
// Backpressure: exercises flush, mid-op reset and a request held through DONE.
module tb_muldiv_sequencer;
  localparam int XLEN     = 32;
  localparam int LAT_FULL = XLEN + 3;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  muldiv_sequencer_if #(.XLEN(XLEN)) bus();

  muldiv_sequencer #(.XLEN(XLEN), .UNROLL(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks    = 0;
  int   failures  = 0;
  int   resp_cnt  = 0;
  int   base_cnt;
  logic [2:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    longint      sa;
    longint      sb;
    longint      ub;
    int          ia;
    int          ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    ia = $signed(a);
    ib = $signed(b);
    ref_res = '0;
    case (op)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; ref_res = p[31:0];  end
      3'd1: begin p = 64'(sa * sb);            ref_res = p[63:32]; end
      3'd2: begin p = 64'(sa * ub);            ref_res = p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; ref_res = p[63:32]; end
      3'd4: ref_res = (b == 0) ? 32'hFFFF_FFFF :
                      ((a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h8000_0000 : 32'(ia / ib));
      3'd5: ref_res = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: ref_res = (b == 0) ? a :
                      ((a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h0 : 32'(ia % ib));
      default: ref_res = (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bit trivial;
    if (!op[2]) trivial = (a == 0) || (b == 0);
    else trivial = (b == 0) || (a == 0) ||
                   ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`ifdef MULDIV_EARLY_OUT_EN
    return trivial ? 2 : LAT_FULL;
`else
    return trivial ? LAT_FULL : LAT_FULL;
`endif
  endfunction

  // Response monitor: every pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.resp_valid_o === 1'b1) begin
      resp_cnt++;
      if (sb_q.size() == 0) begin
        chk("resp_without_req", 32'(sb_q.size()), 32'd1);
      end else begin
        mon_e = sb_q.pop_front();
        chk("result",  bus.result_o, mon_e.res);
        chk("rd_addr", 32'(bus.rd_addr_o), 32'(mon_e.rd));
      end
    end
  end

  task automatic drive_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    bus.req_valid_i = 1'b1;
    bus.op_i        = op;
    bus.rs1_i       = a;
    bus.rs2_i       = b;
    bus.rd_addr_i   = rd;
  endtask

  // Called just after a posedge with the DUT idle; returns just after the posedge following DONE
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp, input bit hold, input string tag);
    int   lat;
    bit   done;
    bit   stall_ok;
    exp_t e;
    e.res = exp;
    e.rd  = rd;
    sb_q.push_back(e);
    drive_req(op, a, b, rd);
    stall_ok = 1'b1;
    @(negedge clk);
    if (bus.stall_o !== 1'b1) stall_ok = 1'b0;
    @(posedge clk); #1;
    if (!hold) bus.req_valid_i = 1'b0;
    lat  = 1;
    done = 1'b0;
    while (!done && lat < 200) begin
      @(negedge clk);
      if (bus.resp_valid_o === 1'b1) begin
        done = 1'b1;
      end else begin
        if (bus.stall_o !== 1'b1) stall_ok = 1'b0;
        @(posedge clk); #1;
        lat++;
      end
    end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_latency(op, a, b)));
    chk({tag, "_stall_busy"}, 32'(stall_ok), 32'd1);
    chk({tag, "_stall_done"}, 32'(bus.stall_o), 32'd0);
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid_i = 1'b0;
    bus.op_i        = '0;
    bus.rs1_i       = '0;
    bus.rs2_i       = '0;
    bus.rd_addr_i   = '0;
    bus.flush_i     = 1'b0;
    rst_n           = 1'b0;
    #2;
    chk("rst_busy",   32'(bus.busy_o), 32'd0);
    chk("rst_ready",  32'(bus.req_ready_o), 32'd1);
    chk("rst_stall",  32'(bus.stall_o), 32'd0);
    chk("rst_resp",   32'(bus.resp_valid_o), 32'd0);
    chk("rst_result", bus.result_o, 32'd0);
    chk("rst_rd",     32'(bus.rd_addr_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(3'd0, 32'd7,          32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, 1'b0, "mul");
    run_op(3'd1, 32'h8000_0000,  32'h8000_0000, 5'd2,  32'h4000_0000, 1'b0, "mulh");
    run_op(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFE, 1'b0, "mulhu");
    run_op(3'd2, 32'hFFFF_FFFF,  32'd2,         5'd4,  32'hFFFF_FFFF, 1'b0, "mulhsu");
    run_op(3'd4, 32'hFFFF_FFF9,  32'd2,         5'd5,  32'hFFFF_FFFD, 1'b0, "div");
    run_op(3'd6, 32'hFFFF_FFF9,  32'd2,         5'd6,  32'hFFFF_FFFF, 1'b0, "rem");
    run_op(3'd5, 32'd100,        32'd7,         5'd7,  32'd14,        1'b0, "divu");
    run_op(3'd7, 32'd100,        32'd7,         5'd8,  32'd2,         1'b0, "remu");
    run_op(3'd5, 32'h1234,       32'd0,         5'd9,  32'hFFFF_FFFF, 1'b0, "divu_by0");
    run_op(3'd6, 32'h1234,       32'd0,         5'd10, 32'h1234,      1'b0, "rem_by0");
    run_op(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1'b0, "div_ovf");
    run_op(3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd12, 32'h0,         1'b0, "rem_ovf");
    run_op(3'd4, 32'hFFFF_FF00,  32'd0,         5'd13, 32'hFFFF_FFFF, 1'b0, "div_neg_by0");
    run_op(3'd0, 32'd0,          32'h1234_5678, 5'd14, 32'd0,         1'b0, "mul_zero");

    for (int i = 0; i < 12; i++) begin
      r_op = 3'($urandom_range(0, 7));
      r_a  = $urandom;
      case ($urandom_range(0, 3))
        0:       r_b = 32'($urandom_range(0, 9));
        1:       r_b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        default: r_b = $urandom;
      endcase
      run_op(r_op, r_a, r_b, 5'(i + 15), ref_res(r_op, r_a, r_b), 1'b0, "rand");
    end

    // Flush at cycle 10 of a DIV; the next request is accepted at cycle 11
    base_cnt = resp_cnt;
    drive_req(3'd4, 32'd1000, 32'd3, 5'd30);
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    bus.flush_i = 1'b1;
    #1;
    chk("flush_stall", 32'(bus.stall_o), 32'd0);
    chk("flush_resp",  32'(bus.resp_valid_o), 32'd0);
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    chk("flush_busy",  32'(bus.busy_o), 32'd0);
    run_op(3'd5, 32'd1000, 32'd3, 5'd31, 32'd333, 1'b0, "after_flush");
    chk("flush_pulses", 32'(resp_cnt - base_cnt), 32'd1);

    // Request held high through DONE must produce exactly one response
    base_cnt = resp_cnt;
    run_op(3'd0, 32'd12345, 32'd678, 5'd17, 32'd8369910, 1'b1, "hold");
    repeat (40) begin
      @(posedge clk); #1;
    end
    chk("hold_pulses", 32'(resp_cnt - base_cnt), 32'd1);
    chk("hold_busy",   32'(bus.busy_o), 32'd0);

    // Reset at cycle 20 of a MUL clears outputs immediately and yields no response
    base_cnt = resp_cnt;
    drive_req(3'd0, 32'd3, 32'd5, 5'd21);
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    repeat (19) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_busy",   32'(bus.busy_o), 32'd0);
    chk("midrst_ready",  32'(bus.req_ready_o), 32'd1);
    chk("midrst_stall",  32'(bus.stall_o), 32'd0);
    chk("midrst_resp",   32'(bus.resp_valid_o), 32'd0);
    chk("midrst_result", bus.result_o, 32'd0);
    chk("midrst_rd",     32'(bus.rd_addr_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
    end
    chk("midrst_pulses", 32'(resp_cnt - base_cnt), 32'd0);
    chk("sb_drained",    32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
